// File: rtl/crack_scheduler.sv
// crack_scheduler: hands fixed-size keyspace chunks to NUM_CORES crack engines and reports the first key found
//   clk, rst_n             clock, asynchronous active-low reset
//   en / rdy               start request, accepted while idle (rdy=1)
//   key / key_valid        first recovered key; key_valid=0 means exhausted or never run
//   core_en                one-cycle start pulse per core (combinational, with core_base valid alongside)
//   core_base              24-bit chunk base per core, held while that core is busy
//   core_rdy/found/key     per-core idle flag, found flag and found key
module crack_scheduler #(
    parameter int NUM_CORES  = 2,
    parameter int CHUNK_LOG2 = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    output logic                    rdy,
    output logic [23:0]             key,
    output logic                    key_valid,
    output logic [NUM_CORES-1:0]    core_en,
    output logic [24*NUM_CORES-1:0] core_base,
    input  logic [NUM_CORES-1:0]    core_rdy,
    input  logic [NUM_CORES-1:0]    core_found,
    input  logic [24*NUM_CORES-1:0] core_key
);
    typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, DONE} state_t;
    state_t                  state_q, state_d;
    logic [NUM_CORES-1:0]    busy_q, busy_d, en_prev_q, done_c;
    logic [24*NUM_CORES-1:0] base_q, base_d;
    logic [24:0]             next_base_q, next_base_d;
    logic [23:0]             key_q, key_d;
    logic                    found_q, found_d, key_valid_q, key_valid_d, hit, sel;

    // a core's rdy is not trusted in the cycle right after its start pulse
    assign done_c    = busy_q & core_rdy & ~en_prev_q;
    assign rdy       = state_q == IDLE;
    assign key       = key_q;
    assign key_valid = key_valid_q;
    // the base must be visible in the same cycle as the pulse, so expose the next value
    assign core_base = base_d;

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        base_d      = base_q;
        next_base_d = next_base_q;
        key_d       = key_q;
        found_d     = found_q;
        key_valid_d = key_valid_q;
        core_en     = '0;
        hit         = 1'b0;
        sel         = 1'b0;
        case (state_q)
            IDLE: if (en) begin
                next_base_d = '0;
                found_d     = 1'b0;
                key_valid_d = 1'b0;
                busy_d      = '0;
                state_d     = DISPATCH;
            end
            DISPATCH: begin
                busy_d = busy_q & ~done_c;
                for (int i = 0; i < NUM_CORES; i++)
                    if (done_c[i] && core_found[i] && !hit) begin
                        hit   = 1'b1;
                        key_d = core_key[24*i +: 24];
                    end
                if (hit) begin
                    found_d = 1'b1;
                    state_d = DRAIN;
                end else if (next_base_q[24]) begin
                    state_d = DRAIN;
                end else begin
                    // a core completing this cycle still has busy_q set, so it waits one cycle
                    for (int i = 0; i < NUM_CORES; i++)
                        if (!busy_q[i] && core_rdy[i] && !sel) begin
                            sel                 = 1'b1;
                            core_en[i]          = 1'b1;
                            base_d[24*i +: 24]  = next_base_q[23:0];
                            busy_d[i]           = 1'b1;
                            next_base_d         = next_base_q + (25'd1 << CHUNK_LOG2);
                        end
                end
            end
            DRAIN: begin
                busy_d  = busy_q & ~done_c;
                state_d = busy_q == '0 ? DONE : DRAIN;
            end
            DONE: begin
                key_valid_d = found_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            busy_q      <= '0;
            en_prev_q   <= '0;
            base_q      <= '0;
            next_base_q <= '0;
            key_q       <= '0;
            found_q     <= 1'b0;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            en_prev_q   <= core_en;
            base_q      <= base_d;
            next_base_q <= next_base_d;
            key_q       <= key_d;
            found_q     <= found_d;
            key_valid_q <= key_valid_d;
        end
    end
endmodule

// File: tb/tb_crack_scheduler.sv
// tb_crack_scheduler: stub crack engines, dispatch monitor and completion-order key model around crack_scheduler
module tb_crack_scheduler;
    logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0;
    logic        rdy, key_valid;
    logic [23:0] key;
    logic [1:0]  core_en, core_rdy, core_found;
    logic [47:0] core_base, core_key;

    always #5 clk = ~clk;

    crack_scheduler #(.NUM_CORES(2), .CHUNK_LOG2(12)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy), .key(key), .key_valid(key_valid),
        .core_en(core_en), .core_base(core_base), .core_rdy(core_rdy),
        .core_found(core_found), .core_key(core_key)
    );

    // stub engines: busy for lat cycles after a pulse; lazy ones keep rdy high one extra cycle
    int          lat[2]   = '{3, 3};
    logic        lazy[2]  = '{1'b0, 1'b0};
    int          cnt[2]   = '{0, 0};
    logic        js[2]    = '{1'b0, 1'b0};
    logic        fnd[2]   = '{1'b0, 1'b0};
    logic [23:0] sbase[2] = '{24'h0, 24'h0};
    logic [23:0] skey[2]  = '{24'h0, 24'h0};
    logic        hit_tab[4096];
    logic [23:0] key_tab[4096];

    always @(posedge clk)
        for (int i = 0; i < 2; i++) begin
            if (core_en[i]) begin
                cnt[i]   <= lat[i];
                sbase[i] <= core_base[24*i +: 24];
                js[i]    <= 1'b1;
            end else begin
                js[i] <= 1'b0;
                if (cnt[i] > 0) begin
                    cnt[i] <= cnt[i] - 1;
                    if (cnt[i] == 1) begin
                        fnd[i]  <= hit_tab[sbase[i][23:12]];
                        skey[i] <= key_tab[sbase[i][23:12]];
                    end
                end
            end
        end

    always_comb
        for (int i = 0; i < 2; i++) begin
            core_rdy[i]            = cnt[i] == 0 || (lazy[i] && js[i]);
            core_found[i]          = fnd[i];
            core_key[24*i +: 24]   = skey[i];
        end

    // monitor + model: dispatch order/uniqueness, base stability, first finder by completion time then index
    int          pulses = 0, seq_err = 0, dup_err = 0, cyc = 0;
    int          pulses_c[2] = '{0, 0};
    int          prev_cnt[2] = '{0, 0};
    int          pk_core[3], pk_cyc[3];
    logic [23:0] pk_base[3];
    logic [24:0] exp_base = '0;
    logic [23:0] last_base = '0, mon_b, m_key = '0;
    logic        m_found = 1'b0;
    logic        seen[4096];

    always @(negedge clk) begin
        cyc++;
        if (en && rdy) begin
            pulses = 0; pulses_c = '{0, 0}; seq_err = 0; dup_err = 0;
            exp_base = '0; m_found = 1'b0;
            for (int c = 0; c < 4096; c++) seen[c] = 1'b0;
        end
        if ($countones(core_en) > 1) seq_err++;
        for (int i = 0; i < 2; i++) begin
            if (core_en[i]) begin
                mon_b = core_base[24*i +: 24];
                if ({1'b0, mon_b} != exp_base) seq_err++;
                if (seen[mon_b[23:12]]) dup_err++;
                seen[mon_b[23:12]] = 1'b1;
                if (pulses < 3) begin
                    pk_core[pulses] = i; pk_cyc[pulses] = cyc; pk_base[pulses] = mon_b;
                end
                pulses++; pulses_c[i]++;
                exp_base = exp_base + 25'h1000;
                last_base = mon_b;
            end
            if (cnt[i] > 0 && core_base[24*i +: 24] != sbase[i]) seq_err++;
            if (cnt[i] == 0 && prev_cnt[i] != 0 && fnd[i] && !m_found) begin
                m_found = 1'b1;
                m_key   = skey[i];
            end
            prev_cnt[i] = cnt[i];
        end
    end

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic setup(input int l0, input int l1, input logic z0, input logic z1);
        for (int c = 0; c < 4096; c++) begin
            hit_tab[c] = 1'b0;
            key_tab[c] = 24'h0;
        end
        lat[0] = l0; lat[1] = l1; lazy[0] = z0; lazy[1] = z1;
    endtask

    task automatic run(input string name);
        int n;
        @(posedge clk); #1 en = 1'b1;
        @(posedge clk); #1 en = 1'b0;
        n = 0;
        while (!rdy && n < 60000) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_timeout"}, 32'(n < 60000), 1);
        chk({name, "_rdy"}, 32'(rdy), 1);
        chk({name, "_seq_err"}, seq_err, 0);
        chk({name, "_dup_err"}, dup_err, 0);
        chk({name, "_first_core"}, pk_core[0], 0);
        chk({name, "_first_base"}, pk_base[0], 0);
        chk({name, "_second_core"}, pk_core[1], 1);
        chk({name, "_second_base"}, pk_base[1], 24'h001000);
        chk({name, "_second_gap"}, pk_cyc[1] - pk_cyc[0], 1);
        if (pulses >= 3) chk({name, "_third_base"}, pk_base[2], 24'h002000);
    endtask

    typedef struct {
        int          l0, l1;
        logic        z0, z1;
        int          c0;
        logic [23:0] k0;
        int          c1;
        logic [23:0] k1;
        logic        ev;
        logic [23:0] ek;
        int          ep;
    } vec_t;

    vec_t tab[5];

    initial begin
        tab[0] = '{50, 50, 1'b0, 1'b0,  3, 24'h0034A7, -1, 24'h0,      1'b1, 24'h0034A7, 0};
        tab[1] = '{20, 19, 1'b0, 1'b0,  0, 24'h000111,  1, 24'h001222, 1'b1, 24'h000111, 0};
        tab[2] = '{ 5, 30, 1'b1, 1'b1,  0, 24'h000AAA,  1, 24'h001BBB, 1'b1, 24'h000AAA, 0};
        tab[3] = '{30,  5, 1'b1, 1'b1,  2, 24'h002CCC, -1, 24'h0,      1'b1, 24'h002CCC, 0};
        tab[4] = '{ 2,  3, 1'b1, 1'b0, -1, 24'h0,      -1, 24'h0,      1'b0, 24'h0,      4096};
        setup(3, 3, 1'b0, 1'b0);
        // reset holds everything idle even with en high
        en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdy", 32'(rdy), 1);
        chk("rst_key_valid", 32'(key_valid), 0);
        chk("rst_key", key, 0);
        chk("rst_core_en", 32'(core_en), 0);
        chk("rst_core_base", core_base[31:0] | core_base[47:32], 0);
        en = 1'b0;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_no_dispatch", pulses, 0);
        chk("rst_idle_rdy", 32'(rdy), 1);
        for (int r = 0; r < 5; r++) begin
            setup(tab[r].l0, tab[r].l1, tab[r].z0, tab[r].z1);
            if (tab[r].c0 >= 0) begin hit_tab[tab[r].c0] = 1'b1; key_tab[tab[r].c0] = tab[r].k0; end
            if (tab[r].c1 >= 0) begin hit_tab[tab[r].c1] = 1'b1; key_tab[tab[r].c1] = tab[r].k1; end
            run($sformatf("row%0d", r));
            chk($sformatf("row%0d_key_valid", r), 32'(key_valid), 32'(tab[r].ev));
            if (tab[r].ev) chk($sformatf("row%0d_key", r), key, tab[r].ek);
            if (tab[r].ep != 0) begin
                chk($sformatf("row%0d_pulses", r), pulses, tab[r].ep);
                chk($sformatf("row%0d_last_base", r), last_base, 24'hFFF000);
            end
            if (tab[r].l0 <= tab[r].l1 && pulses >= 3) chk($sformatf("row%0d_third_core", r), pk_core[2], 0);
        end
        // randomized searches against the completion-order model
        for (int r = 0; r < 6; r++) begin
            int c;
            setup($urandom_range(2, 12), $urandom_range(2, 12), 1'($urandom), 1'($urandom));
            for (int h = 0; h <= int'($urandom_range(0, 2)); h++) begin
                c = $urandom_range(0, 40);
                hit_tab[c] = 1'b1;
                key_tab[c] = 24'($urandom);
            end
            run($sformatf("rnd%0d", r));
            chk($sformatf("rnd%0d_key_valid", r), 32'(key_valid), 32'(m_found));
            chk($sformatf("rnd%0d_key", r), key, m_key);
        end
        // reset in the middle of a dispatch phase
        setup(50, 50, 1'b0, 1'b0);
        @(posedge clk); #1 en = 1'b1;
        @(posedge clk); #1 en = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_rdy", 32'(rdy), 1);
        chk("midrst_key_valid", 32'(key_valid), 0);
        chk("midrst_core_en", 32'(core_en), 0);
        chk("midrst_core_base", core_base[31:0] | core_base[47:32], 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (60) @(posedge clk);
        setup(3, 3, 1'b0, 1'b0);
        hit_tab[0] = 1'b1;
        key_tab[0] = 24'h00ABCD;
        run("restart");
        chk("restart_key_valid", 32'(key_valid), 1);
        chk("restart_key", key, 24'h00ABCD);
        // one slow core: the fast one takes most of the work, every chunk exactly once
        setup(4, 40, 1'b0, 1'b1);
        run("slow");
        chk("slow_pulses", pulses, 4096);
        chk("slow_last_base", last_base, 24'hFFF000);
        chk("slow_core0_more", 32'(pulses_c[0] > pulses_c[1]), 1);
        chk("slow_key_valid", 32'(key_valid), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
